// File: rtl/msrv32_branch_ctrl.sv
// ---------------------------------------------------------------------------
// msrv32_branch_ctrl
//
// Sequences a redirect and flush between the branch unit and the fetch stage.
// A resolved branch that is accepted in IDLE is counted. Three outcomes follow:
//   - not taken: nothing else happens.
//   - taken to a misaligned target: one-cycle misaligned pulse, no redirect.
//   - taken to an aligned target: the target is latched, the taken counter
//     increments, and the controller enters REDIRECT.
// In REDIRECT the controller holds a redirect request, with a stable PC, until
// instruction memory accepts it. It then spends FLUSH_CYCLES cycles in FLUSH,
// killing wrong-path IF/ID contents. A trap redirect aborts the sequence in
// any state.
//
// Ports:
//   ms_riscv32_mp_clk_in  - clock, rising edge
//   ms_riscv32_mp_rst_in  - asynchronous active-low reset
//   branch_valid_in       - branch/JAL/JALR resolved in execute this cycle
//   branch_taken_in       - branch decision (1 for JAL/JALR)
//   target_addr_in        - computed target address
//   stall_in              - pipeline stall; blocks acceptance of a branch
//   trap_taken_in         - trap redirect in progress; highest priority
//   imem_ready_in         - instruction memory accepts the fetch address
//   redirect_valid_out    - redirect request to fetch
//   redirect_pc_out       - redirect address
//   flush_out             - kill IF/ID contents
//   stall_fetch_out       - hold PC update
//   misaligned_instr_out  - one-cycle instruction-address-misaligned pulse
//   branch_cnt_out        - accepted resolved branches
//   taken_cnt_out         - accepted taken, aligned branches
// ---------------------------------------------------------------------------
module msrv32_branch_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 ms_riscv32_mp_clk_in,
  input  logic                 ms_riscv32_mp_rst_in,
  input  logic                 branch_valid_in,
  input  logic                 branch_taken_in,
  input  logic [31:0]          target_addr_in,
  input  logic                 stall_in,
  input  logic                 trap_taken_in,
  input  logic                 imem_ready_in,
  output logic                 redirect_valid_out,
  output logic [31:0]          redirect_pc_out,
  output logic                 flush_out,
  output logic                 stall_fetch_out,
  output logic                 misaligned_instr_out,
  output logic [CNT_WIDTH-1:0] branch_cnt_out,
  output logic [CNT_WIDTH-1:0] taken_cnt_out
);

  // The flush counter must hold FLUSH_CYCLES-1; it is kept at least 1 bit wide.
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  // Value loaded on entry to FLUSH. It is only used when FLUSH_CYCLES > 0.
  localparam logic [FW-1:0] FLUSH_LOAD = (FLUSH_CYCLES > 0) ? FW'(FLUSH_CYCLES - 1) : '0;
  localparam bit SKIP_FLUSH = (FLUSH_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t         state_r;
  logic [FW-1:0]  flush_cnt_r;

  logic           accept_s;
  logic           misaligned_s;
  logic           handshake_s;

  // Decode the acceptance, alignment and handshake conditions for this cycle.
  always_comb begin
    accept_s     = 1'b0;
    misaligned_s = 1'b0;
    handshake_s  = 1'b0;
    if (state_r == IDLE) begin
      accept_s = branch_valid_in & ~stall_in & ~trap_taken_in;
    end else begin
      accept_s = 1'b0;
    end
    if (target_addr_in[1:0] != 2'b00) begin
      misaligned_s = 1'b1;
    end else begin
      misaligned_s = 1'b0;
    end
    // redirect_valid_out is high exactly while in REDIRECT, so it qualifies
    // the handshake directly.
    if ((state_r == REDIRECT) && redirect_valid_out && imem_ready_in) begin
      handshake_s = 1'b1;
    end else begin
      handshake_s = 1'b0;
    end
  end

  // Redirect/flush FSM with registered control outputs and performance counters.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_r              <= IDLE;
      flush_cnt_r          <= '0;
      redirect_valid_out   <= 1'b0;
      redirect_pc_out      <= 32'h0000_0000;
      flush_out            <= 1'b0;
      stall_fetch_out      <= 1'b0;
      misaligned_instr_out <= 1'b0;
      branch_cnt_out       <= '0;
      taken_cnt_out        <= '0;
    end else begin
      // The misaligned flag is a single-cycle pulse unless re-armed below.
      misaligned_instr_out <= 1'b0;
      if (trap_taken_in) begin
        // A trap wins over everything. The PC and the counters are kept.
        state_r            <= IDLE;
        flush_cnt_r        <= '0;
        redirect_valid_out <= 1'b0;
        flush_out          <= 1'b0;
        stall_fetch_out    <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            if (accept_s) begin
              branch_cnt_out <= branch_cnt_out + CNT_WIDTH'(1);
              if (branch_taken_in && misaligned_s) begin
                misaligned_instr_out <= 1'b1;
              end else if (branch_taken_in) begin
                redirect_pc_out    <= target_addr_in;
                taken_cnt_out      <= taken_cnt_out + CNT_WIDTH'(1);
                state_r            <= REDIRECT;
                redirect_valid_out <= 1'b1;
                flush_out          <= 1'b1;
                stall_fetch_out    <= 1'b1;
              end else begin
                state_r <= IDLE;
              end
            end else begin
              state_r <= IDLE;
            end
          end

          REDIRECT: begin
            if (handshake_s) begin
              redirect_valid_out <= 1'b0;
              stall_fetch_out    <= 1'b0;
              if (SKIP_FLUSH) begin
                state_r   <= IDLE;
                flush_out <= 1'b0;
              end else begin
                state_r     <= FLUSH;
                flush_out   <= 1'b1;
                flush_cnt_r <= FLUSH_LOAD;
              end
            end else begin
              // Hold the request and redirect_pc_out until memory accepts it.
              state_r <= REDIRECT;
            end
          end

          FLUSH: begin
            if (flush_cnt_r == '0) begin
              state_r   <= IDLE;
              flush_out <= 1'b0;
            end else begin
              flush_cnt_r <= flush_cnt_r - FW'(1);
            end
          end

          default: begin
            state_r            <= IDLE;
            flush_cnt_r        <= '0;
            redirect_valid_out <= 1'b0;
            flush_out          <= 1'b0;
            stall_fetch_out    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_msrv32_branch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_msrv32_branch_ctrl
//
// Directed testbench for msrv32_branch_ctrl with FLUSH_CYCLES=2 and
// CNT_WIDTH=32. Inputs change on the falling edge. Outputs are sampled on the
// falling edge, which is half a cycle after the rising edge that updates them.
// ---------------------------------------------------------------------------
module tb_msrv32_branch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        branch_valid;
  logic        branch_taken;
  logic [31:0] target_addr;
  logic        stall;
  logic        trap_taken;
  logic        imem_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        stall_fetch;
  logic        misaligned;
  logic [31:0] branch_cnt;
  logic [31:0] taken_cnt;

  int total;
  int bad;

  msrv32_branch_ctrl #(
    .FLUSH_CYCLES(2),
    .CNT_WIDTH(32)
  ) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .branch_valid_in      (branch_valid),
    .branch_taken_in      (branch_taken),
    .target_addr_in       (target_addr),
    .stall_in             (stall),
    .trap_taken_in        (trap_taken),
    .imem_ready_in        (imem_ready),
    .redirect_valid_out   (redirect_valid),
    .redirect_pc_out      (redirect_pc),
    .flush_out            (flush),
    .stall_fetch_out      (stall_fetch),
    .misaligned_instr_out (misaligned),
    .branch_cnt_out       (branch_cnt),
    .taken_cnt_out        (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    branch_valid = 1'b0;
    branch_taken = 1'b0;
    target_addr  = 32'h0000_0000;
    stall        = 1'b0;
    trap_taken   = 1'b0;
  endtask

  task automatic drive_branch(input logic taken, input logic [31:0] tgt);
    branch_valid = 1'b1;
    branch_taken = taken;
    target_addr  = tgt;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    imem_ready = 1'b0;
    idle_inputs();

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_rv",    {31'd0, redirect_valid}, 32'd0);
    check_val("rst_pc",    redirect_pc,             32'd0);
    check_val("rst_flush", {31'd0, flush},          32'd0);
    check_val("rst_bcnt",  branch_cnt,              32'd0);
    rst_n = 1'b1;

    // Asynchronous reset while in REDIRECT
    @(negedge clk);
    drive_branch(1'b1, 32'h0000_2000);
    @(negedge clk);
    idle_inputs();
    check_val("a_rv",   {31'd0, redirect_valid}, 32'd1);
    check_val("a_pc",   redirect_pc,             32'h0000_2000);
    check_val("a_bcnt", branch_cnt,              32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("a_arst_rv",    {31'd0, redirect_valid}, 32'd0);
    check_val("a_arst_flush", {31'd0, flush},          32'd0);
    check_val("a_arst_stf",   {31'd0, stall_fetch},    32'd0);
    check_val("a_arst_pc",    redirect_pc,             32'd0);
    check_val("a_arst_bcnt",  branch_cnt,              32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Not-taken branch
    @(negedge clk);
    drive_branch(1'b0, 32'h0000_0100);
    @(negedge clk);
    idle_inputs();
    check_val("b_rv",    {31'd0, redirect_valid}, 32'd0);
    check_val("b_flush", {31'd0, flush},          32'd0);
    check_val("b_mis",   {31'd0, misaligned},     32'd0);
    check_val("b_bcnt",  branch_cnt,              32'd1);
    check_val("b_tcnt",  taken_cnt,               32'd0);

    // Taken branch, memory ready immediately
    imem_ready = 1'b1;
    drive_branch(1'b1, 32'h0000_2000);
    @(negedge clk);
    idle_inputs();
    check_val("c_rv",    {31'd0, redirect_valid}, 32'd1);
    check_val("c_pc",    redirect_pc,             32'h0000_2000);
    check_val("c_flush", {31'd0, flush},          32'd1);
    check_val("c_stf",   {31'd0, stall_fetch},    32'd1);
    check_val("c_bcnt",  branch_cnt,              32'd2);
    check_val("c_tcnt",  taken_cnt,               32'd1);
    @(negedge clk);
    check_val("c_f1_rv",    {31'd0, redirect_valid}, 32'd0);
    check_val("c_f1_flush", {31'd0, flush},          32'd1);
    check_val("c_f1_stf",   {31'd0, stall_fetch},    32'd0);
    @(negedge clk);
    check_val("c_f2_flush", {31'd0, flush},          32'd1);
    @(negedge clk);
    check_val("c_done_flush", {31'd0, flush},        32'd0);
    imem_ready = 1'b0;

    // Taken branch, memory not ready for 4 cycles
    drive_branch(1'b1, 32'h0000_2000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_inputs();
      check_val($sformatf("d_rv%0d", i),    {31'd0, redirect_valid}, 32'd1);
      check_val($sformatf("d_stf%0d", i),   {31'd0, stall_fetch},    32'd1);
      check_val($sformatf("d_flush%0d", i), {31'd0, flush},          32'd1);
      check_val($sformatf("d_pc%0d", i),    redirect_pc,             32'h0000_2000);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    check_val("d_f1_rv",    {31'd0, redirect_valid}, 32'd0);
    check_val("d_f1_flush", {31'd0, flush},          32'd1);
    @(negedge clk);
    check_val("d_f2_flush", {31'd0, flush},          32'd1);
    @(negedge clk);
    check_val("d_done_flush", {31'd0, flush},        32'd0);
    check_val("d_bcnt", branch_cnt, 32'd3);
    check_val("d_tcnt", taken_cnt,  32'd2);

    // Taken branch to a misaligned target
    drive_branch(1'b1, 32'h0000_2002);
    @(negedge clk);
    idle_inputs();
    check_val("e_mis",  {31'd0, misaligned},     32'd1);
    check_val("e_rv",   {31'd0, redirect_valid}, 32'd0);
    check_val("e_bcnt", branch_cnt,              32'd4);
    check_val("e_tcnt", taken_cnt,               32'd2);
    @(negedge clk);
    check_val("e_mis_end", {31'd0, misaligned},  32'd0);

    // Trap during REDIRECT; a wrong-path branch is not counted
    drive_branch(1'b1, 32'h0000_4000);
    @(negedge clk);
    drive_branch(1'b1, 32'h0000_5000);
    check_val("f_rv",   {31'd0, redirect_valid}, 32'd1);
    check_val("f_pc",   redirect_pc,             32'h0000_4000);
    check_val("f_bcnt", branch_cnt,              32'd5);
    check_val("f_tcnt", taken_cnt,               32'd3);
    @(negedge clk);
    idle_inputs();
    check_val("f_wp_bcnt", branch_cnt,  32'd5);
    check_val("f_wp_pc",   redirect_pc, 32'h0000_4000);
    trap_taken = 1'b1;
    @(negedge clk);
    trap_taken = 1'b0;
    check_val("f_trap_rv",    {31'd0, redirect_valid}, 32'd0);
    check_val("f_trap_flush", {31'd0, flush},          32'd0);
    check_val("f_trap_stf",   {31'd0, stall_fetch},    32'd0);
    check_val("f_trap_pc",    redirect_pc,             32'h0000_4000);
    check_val("f_trap_tcnt",  taken_cnt,               32'd3);

    // A trap beats a simultaneous accept
    drive_branch(1'b1, 32'h0000_6000);
    trap_taken = 1'b1;
    @(negedge clk);
    idle_inputs();
    check_val("g_rv",   {31'd0, redirect_valid}, 32'd0);
    check_val("g_bcnt", branch_cnt,              32'd5);

    // A stalled branch is not accepted
    drive_branch(1'b1, 32'h0000_7000);
    stall = 1'b1;
    @(negedge clk);
    idle_inputs();
    check_val("h_rv",   {31'd0, redirect_valid}, 32'd0);
    check_val("h_bcnt", branch_cnt,              32'd5);
    check_val("h_tcnt", taken_cnt,               32'd3);
    check_val("h_pc",   redirect_pc,             32'h0000_4000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
